// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults and load saturation helper for the cascaded up-counter.
package counter_pkg;
  localparam int DW = 8;
  localparam int LO_MOD_DEF = 10;
  localparam int HI_MOD_DEF = 6;
  function automatic int unsigned sat(input int unsigned value, input int unsigned mod);
    return value < mod ? value : mod - 1;
  endfunction
endpackage

// File: rtl/counter_mod_stage.sv
// counter_mod_stage: one modulo-MOD digit with saturating load and carry in/out.
module counter_mod_stage
  import counter_pkg::*;
#(
  parameter int dw = DW,
  parameter int MOD = LO_MOD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [dw-1:0] load_val,
  input  logic          cin,
  output logic [dw-1:0] count,
  output logic          cout
);
  logic [dw-1:0] count_q, count_d;
  logic          at_max;
  always_comb begin
    at_max  = count_q == dw'(MOD - 1);
    count_d = load ? dw'(sat(32'(load_val), MOD)) : cin ? (at_max ? '0 : count_q + 1'b1) : count_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign cout  = cin && at_max;
endmodule

// File: rtl/counter_up_cascade.sv
// counter_up_cascade: two-digit modulo up-counter with combined result, wrap pulse and target compare.
module counter_up_cascade
  import counter_pkg::*;
#(
  parameter int dw = DW,
  parameter int LO_MOD = LO_MOD_DEF,
  parameter int HI_MOD = HI_MOD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          load,
  input  logic [dw-1:0] load_lo,
  input  logic [dw-1:0] load_hi,
  input  logic [dw-1:0] target,
  output logic [dw-1:0] lo,
  output logic [dw-1:0] hi,
  output logic [dw-1:0] result,
  output logic          tc,
  output logic          hit
);
  if (LO_MOD < 2 || HI_MOD < 1 || longint'(LO_MOD) * longint'(HI_MOD) > (longint'(1) << dw)) begin : g_bad_params
    $error("counter_up_cascade: illegal LO_MOD/HI_MOD for dw");
  end
  logic lo_cout, hi_cout;
  logic tc_q, tc_d;
  counter_mod_stage #(.dw(dw), .MOD(LO_MOD)) u_lo (
    .clk(clk), .reset(reset), .load(load), .load_val(load_lo),
    .cin(ena), .count(lo), .cout(lo_cout)
  );
  counter_mod_stage #(.dw(dw), .MOD(HI_MOD)) u_hi (
    .clk(clk), .reset(reset), .load(load), .load_val(load_hi),
    .cin(lo_cout), .count(hi), .cout(hi_cout)
  );
  // A full wrap only counts when load is not overriding the increment.
  always_comb tc_d = !load && hi_cout;
  always_ff @(posedge clk or posedge reset)
    if (reset) tc_q <= 1'b0;
    else tc_q <= tc_d;
  assign tc     = tc_q;
  assign result = hi * dw'(LO_MOD) + lo;
  assign hit    = result == target;
endmodule
